// File: rtl/dct_pkg.sv
// ----------------------------------------------------------------------------
// dct_pkg : shared constants and types for the 8x8 2-D DCT sequencer (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

package dct_pkg;
   localparam int SAMPLE_W = 16;
   localparam int N        = 8;

   localparam logic [7:0] ADDR_CTRL   = 8'h40;
   localparam logic [7:0] ADDR_STATUS = 8'h41;

   localparam int CTRL_START_BIT  = 0;
   localparam int CTRL_IRQ_EN_BIT = 1;
   localparam int STAT_BUSY_BIT   = 0;
   localparam int STAT_DONE_BIT   = 1;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ROW       = 3'd1,
      ST_ROW_DRAIN = 3'd2,
      ST_COL       = 3'd3,
      ST_COL_DRAIN = 3'd4,
      ST_FIN       = 3'd5
   } seq_state_t;

   // Tag travelling alongside a vector through the core latency
   typedef struct packed {
      logic       vld;
      logic       col;
      logic [2:0] idx;
   } cap_t;
endpackage

`default_nettype wire

// File: rtl/dct_buf_8x8.sv
// ----------------------------------------------------------------------------
// dct_buf_8x8 : 64-entry matrix store with word bus port and row/column vector ports (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

module dct_buf_8x8 import dct_pkg::*; #(
   parameter int SAMPLE_W = 16
) (
   input  logic                  clk,
   input  logic                  bus_we,
   input  logic [5:0]            bus_addr,
   input  logic [SAMPLE_W-1:0]   bus_wdata,
   output logic [SAMPLE_W-1:0]   bus_rdata,
   input  logic                  vec_rd_col,
   input  logic [2:0]            vec_rd_sel,
   output logic [N*SAMPLE_W-1:0] vec_rdata,
   input  logic                  vec_we,
   input  logic                  vec_wr_col,
   input  logic [2:0]            vec_wr_sel,
   input  logic [N*SAMPLE_W-1:0] vec_wdata
);

   logic [SAMPLE_W-1:0] mem [N*N];

   assign bus_rdata = mem[bus_addr];

   // Element k of a row vector is mem[8*sel+k]; of a column vector, mem[8*k+sel]
   for (genvar k = 0; k < N; k++) begin : g_lane
      assign vec_rdata[k*SAMPLE_W +: SAMPLE_W] =
         vec_rd_col ? mem[{3'(k), vec_rd_sel}] : mem[{vec_rd_sel, 3'(k)}];
   end

   always_ff @(posedge clk) begin
      if (bus_we)
         mem[bus_addr] <= bus_wdata;
      if (vec_we) begin
         for (int k = 0; k < N; k++) begin
            if (vec_wr_col)
               mem[{3'(k), vec_wr_sel}] <= vec_wdata[k*SAMPLE_W +: SAMPLE_W];
            else
               mem[{vec_wr_sel, 3'(k)}] <= vec_wdata[k*SAMPLE_W +: SAMPLE_W];
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/dct2d_seq_ctrl.sv
// ----------------------------------------------------------------------------
// dct2d_seq_ctrl : Avalon-MM sequencer running a 1-D DCT core over rows then columns (rev 1.0)
// Optional macro DCT_IRQ_EN adds the registered ins_irq output.
// ----------------------------------------------------------------------------
`default_nettype none

module dct2d_seq_ctrl import dct_pkg::*; #(
   parameter int SAMPLE_W = 16,
   parameter int CORE_LAT = 0
) (
   input  logic                  csi_clk,
   input  logic                  rsi_reset,
   input  logic [7:0]            avs_s0_address,
   input  logic                  avs_s0_write,
   input  logic [31:0]           avs_s0_writedata,
   input  logic                  avs_s0_read,
   output logic [31:0]           avs_s0_readdata,
`ifdef DCT_IRQ_EN
   output logic                  ins_irq,
`endif
   output logic [N*SAMPLE_W-1:0] dct_x_o,
   input  logic [N*SAMPLE_W-1:0] dct_y_i
);

   localparam logic [2:0] c_drain_last = 3'(CORE_LAT - 1);

   seq_state_t r_state;
   logic [2:0]  r_cnt;
   logic        r_busy;
   logic        r_done;
   logic [31:0] r_rdata;

   logic        w_smp_wr, w_ctrl_wr, w_stat_wr, w_start, w_issue;
   logic        w_done_nxt, w_irq_en;
   logic [31:0] w_rd_mux;
   logic [SAMPLE_W-1:0]   w_sbuf_rdata;
   logic [N*SAMPLE_W-1:0] w_sbuf_vec, w_tbuf_vec;
   cap_t        w_cap;

   assign w_smp_wr  = avs_s0_write && (avs_s0_address[7:6] == 2'b00) && !r_busy;
   assign w_ctrl_wr = avs_s0_write && (avs_s0_address == ADDR_CTRL);
   assign w_stat_wr = avs_s0_write && (avs_s0_address == ADDR_STATUS);
   assign w_start   = w_ctrl_wr && avs_s0_writedata[CTRL_START_BIT] && !r_busy;
   assign w_issue   = (r_state == ST_ROW) || (r_state == ST_COL);

   always_ff @(posedge csi_clk or posedge rsi_reset) begin
      if (rsi_reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= 3'd0;
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_cnt <= 3'd0;
               if (w_start) begin
                  r_state <= ST_ROW;
                  r_busy  <= 1'b1;
               end
            end
            ST_ROW: begin
               r_cnt <= r_cnt + 3'd1;
               if (r_cnt == 3'd7)
                  r_state <= (CORE_LAT == 0) ? ST_COL : ST_ROW_DRAIN;
            end
            ST_ROW_DRAIN: begin
               r_cnt <= (r_cnt == c_drain_last) ? 3'd0 : r_cnt + 3'd1;
               if (r_cnt == c_drain_last)
                  r_state <= ST_COL;
            end
            ST_COL: begin
               r_cnt <= r_cnt + 3'd1;
               if (r_cnt == 3'd7)
                  r_state <= (CORE_LAT == 0) ? ST_FIN : ST_COL_DRAIN;
            end
            ST_COL_DRAIN: begin
               r_cnt <= (r_cnt == c_drain_last) ? 3'd0 : r_cnt + 3'd1;
               if (r_cnt == c_drain_last)
                  r_state <= ST_FIN;
            end
            ST_FIN: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // Results return CORE_LAT cycles after issue; the tag says where they land
   generate
      if (CORE_LAT == 0) begin : g_lat0
         always_comb begin
            w_cap     = '0;
            w_cap.vld = w_issue;
            w_cap.col = (r_state == ST_COL);
            w_cap.idx = r_cnt;
         end
      end else begin : g_pipe
         cap_t r_pipe [CORE_LAT];
         always_ff @(posedge csi_clk or posedge rsi_reset) begin
            if (rsi_reset) begin
               for (int k = 0; k < CORE_LAT; k++)
                  r_pipe[k] <= '0;
            end else begin
               r_pipe[0] <= '{vld: w_issue, col: (r_state == ST_COL), idx: r_cnt};
               for (int k = 1; k < CORE_LAT; k++)
                  r_pipe[k] <= r_pipe[k-1];
            end
         end
         assign w_cap = r_pipe[CORE_LAT-1];
      end
   endgenerate

   dct_buf_8x8 #(.SAMPLE_W(SAMPLE_W)) u_sbuf (
      .clk        (csi_clk),
      .bus_we     (w_smp_wr),
      .bus_addr   (avs_s0_address[5:0]),
      .bus_wdata  (avs_s0_writedata[SAMPLE_W-1:0]),
      .bus_rdata  (w_sbuf_rdata),
      .vec_rd_col (1'b0),
      .vec_rd_sel (r_cnt),
      .vec_rdata  (w_sbuf_vec),
      .vec_we     (w_cap.vld && w_cap.col),
      .vec_wr_col (1'b1),
      .vec_wr_sel (w_cap.idx),
      .vec_wdata  (dct_y_i)
   );

   dct_buf_8x8 #(.SAMPLE_W(SAMPLE_W)) u_tbuf (
      .clk        (csi_clk),
      .bus_we     (1'b0),
      .bus_addr   (6'd0),
      .bus_wdata  ('0),
      .bus_rdata  (),
      .vec_rd_col (1'b1),
      .vec_rd_sel (r_cnt),
      .vec_rdata  (w_tbuf_vec),
      .vec_we     (w_cap.vld && !w_cap.col),
      .vec_wr_col (1'b0),
      .vec_wr_sel (w_cap.idx),
      .vec_wdata  (dct_y_i)
   );

   always_comb begin
      dct_x_o = '0;
      if (r_state == ST_ROW)
         dct_x_o = w_sbuf_vec;
      else if (r_state == ST_COL)
         dct_x_o = w_tbuf_vec;
   end

   always_comb begin
      w_done_nxt = r_done;
      if (w_start || (w_stat_wr && avs_s0_writedata[STAT_DONE_BIT]))
         w_done_nxt = 1'b0;
      if (r_state == ST_FIN)
         w_done_nxt = 1'b1;
   end

   always_comb begin
      w_rd_mux = '0;
      if (avs_s0_address[7:6] == 2'b00) begin
         w_rd_mux = 32'(w_sbuf_rdata);
      end else if (avs_s0_address == ADDR_CTRL) begin
         w_rd_mux[CTRL_IRQ_EN_BIT] = w_irq_en;
      end else if (avs_s0_address == ADDR_STATUS) begin
         w_rd_mux[STAT_BUSY_BIT] = r_busy;
         w_rd_mux[STAT_DONE_BIT] = r_done;
      end
   end

   always_ff @(posedge csi_clk or posedge rsi_reset) begin
      if (rsi_reset) begin
         r_done  <= 1'b0;
         r_rdata <= '0;
      end else begin
         r_done <= w_done_nxt;
         if (avs_s0_read)
            r_rdata <= w_rd_mux;
      end
   end

   assign avs_s0_readdata = r_rdata;

`ifdef DCT_IRQ_EN
   logic r_irq_en;
   logic r_irq;
   logic w_irq_en_nxt;

   assign w_irq_en_nxt = w_ctrl_wr ? avs_s0_writedata[CTRL_IRQ_EN_BIT] : r_irq_en;

   // Built from next-state values so the interrupt rises on the same edge as DONE
   always_ff @(posedge csi_clk or posedge rsi_reset) begin
      if (rsi_reset) begin
         r_irq_en <= 1'b0;
         r_irq    <= 1'b0;
      end else begin
         r_irq_en <= w_irq_en_nxt;
         r_irq    <= w_done_nxt && w_irq_en_nxt;
      end
   end

   assign w_irq_en = r_irq_en;
   assign ins_irq  = r_irq;
`else
   assign w_irq_en = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dct2d_seq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_dct2d_seq_ctrl : scoreboard bench with combinational and 3-cycle core stubs (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

module tb_dct2d_seq_ctrl;
   import dct_pkg::*;

   logic         clk = 1'b0;
   logic         rst;
   logic [7:0]   address;
   logic         write, read;
   logic [31:0]  writedata;
   logic         sel;
   logic         dc_mode;
   logic [31:0]  rd0, rd1, rdm;
   logic [127:0] x0, x1, y0, y1;
   logic [127:0] p1 [3];
   logic         irq0, irq1;

   int total = 0;
   int bad   = 0;

   logic [31:0] exp_q [$];
   string       tag_q [$];
   logic [15:0] smp [64];
   logic [15:0] res [64];

   always #5 clk = ~clk;

   function automatic logic [127:0] core_f(input logic [127:0] x, input logic dc);
      logic [15:0] s;
      if (!dc) return x;
      s = 16'd0;
      for (int k = 0; k < 8; k++) s = s + x[k*16 +: 16];
      return {112'd0, s};
   endfunction

   assign y0 = core_f(x0, dc_mode);
   always @(posedge clk) begin
      p1[0] <= core_f(x1, dc_mode);
      p1[1] <= p1[0];
      p1[2] <= p1[1];
   end
   assign y1 = p1[2];

   dct2d_seq_ctrl #(.SAMPLE_W(16), .CORE_LAT(0)) u_dut0 (
      .csi_clk          (clk),
      .rsi_reset        (rst),
      .avs_s0_address   (address),
      .avs_s0_write     (write & ~sel),
      .avs_s0_writedata (writedata),
      .avs_s0_read      (read & ~sel),
      .avs_s0_readdata  (rd0),
`ifdef DCT_IRQ_EN
      .ins_irq          (irq0),
`endif
      .dct_x_o          (x0),
      .dct_y_i          (y0)
   );

   dct2d_seq_ctrl #(.SAMPLE_W(16), .CORE_LAT(3)) u_dut1 (
      .csi_clk          (clk),
      .rsi_reset        (rst),
      .avs_s0_address   (address),
      .avs_s0_write     (write & sel),
      .avs_s0_writedata (writedata),
      .avs_s0_read      (read & sel),
      .avs_s0_readdata  (rd1),
`ifdef DCT_IRQ_EN
      .ins_irq          (irq1),
`endif
      .dct_x_o          (x1),
      .dct_y_i          (y1)
   );

`ifndef DCT_IRQ_EN
   assign irq0 = 1'b0;
   assign irq1 = 1'b0;
`endif

   assign rdm = sel ? rd1 : rd0;

   task automatic expect_push(input string tag, input logic [31:0] e);
      exp_q.push_back(e);
      tag_q.push_back(tag);
   endtask

   task automatic expect_pop(input logic [31:0] got);
      logic [31:0] e;
      string t;
      total++;
      if (exp_q.size() == 0) begin
         bad++;
         $error("FAIL scoreboard_empty got=%0h", got);
         return;
      end
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (got === e) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", t, got, e);
      end
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      @(negedge clk);
      address = a; writedata = d; write = 1'b1;
      @(negedge clk);
      write = 1'b0;
   endtask

   task automatic rd(input logic [7:0] a, input logic [31:0] e, input string tag);
      @(negedge clk);
      address = a; read = 1'b1;
      expect_push(tag, e);
      @(negedge clk);
      read = 1'b0;
      expect_pop(rdm);
   endtask

   task automatic load_random();
      logic [31:0] w;
      for (int a = 0; a < 64; a++) begin
         w = $urandom();
         smp[a] = w[15:0];
         wr(8'(a), w);
      end
   endtask

   task automatic load_fixed();
      for (int a = 0; a < 64; a++) wr(8'(a), {16'hA5A5, smp[a]});
   endtask

   // Reference 2-D transform: core over every row, then over every column
   task automatic model2d(input logic dc);
      logic [15:0]  t [64];
      logic [127:0] v, y;
      for (int r = 0; r < 8; r++) begin
         for (int k = 0; k < 8; k++) v[k*16 +: 16] = smp[8*r + k];
         y = core_f(v, dc);
         for (int k = 0; k < 8; k++) t[8*r + k] = y[k*16 +: 16];
      end
      for (int c = 0; c < 8; c++) begin
         for (int k = 0; k < 8; k++) v[k*16 +: 16] = t[8*k + c];
         y = core_f(v, dc);
         for (int k = 0; k < 8; k++) res[8*k + c] = y[k*16 +: 16];
      end
   endtask

   task automatic check_all(input string pre);
      for (int a = 0; a < 64; a++) rd(8'(a), {16'd0, res[a]}, $sformatf("%s_smp%0d", pre, a));
   endtask

   // START, optional interference while busy, then poll STATUS every cycle
   task automatic run(input logic [31:0] ctrl, input logic meddle, input int exp_busy);
      int n;
      int guard;
      @(negedge clk);
      address = ADDR_CTRL; writedata = ctrl; write = 1'b1;
      n = 0;
      if (meddle) begin
         @(negedge clk);
         address = 8'd5; writedata = 32'h0000BEEF;
         @(negedge clk);
         address = ADDR_CTRL; writedata = ctrl;
         n = 2;
      end
      @(negedge clk);
      write = 1'b0; address = ADDR_STATUS; read = 1'b1;
      expect_push("status_first", 32'h1);
      @(negedge clk);
      expect_pop(rdm);
      if (rdm[0]) n++;
      guard = 0;
      while (rdm[0] && guard < 200) begin
         @(negedge clk);
         if (rdm[0]) n++;
         guard++;
      end
      read = 1'b0;
      expect_push("busy_cycles", 32'(exp_busy));
      expect_pop(32'(n));
      expect_push("status_done", 32'h2);
      expect_pop(rdm);
   endtask

   initial begin
      rst = 1'b1; read = 1'b0; write = 1'b0; address = 8'd0;
      writedata = 32'd0; sel = 1'b0; dc_mode = 1'b0;
      repeat (3) @(negedge clk);
      expect_push("rst_rdata0", 32'd0); expect_pop(rd0);
      expect_push("rst_rdata1", 32'd0); expect_pop(rd1);
      expect_push("rst_x0", 32'd0);     expect_pop(32'(|x0));
      rst = 1'b0;
      rd(ADDR_STATUS, 32'd0, "rst_status");
      rd(ADDR_CTRL,   32'd0, "rst_ctrl");

      // Passthrough, SAMPLE[a] = a
      for (int a = 0; a < 64; a++) smp[a] = 16'(a);
      load_fixed();
      model2d(1'b0);
      run(32'h1, 1'b0, 17);
      check_all("pt");
      rd(8'h42, 32'd0, "unmapped42");
      rd(8'hFF, 32'd0, "unmappedFF");

      // DC stub, all ones -> 64 at origin
      dc_mode = 1'b1;
      for (int a = 0; a < 64; a++) smp[a] = 16'd1;
      load_fixed();
      model2d(1'b1);
      run(32'h1, 1'b0, 17);
      check_all("dc");

      // Interference while busy: extra START and SAMPLE[5] write ignored
      dc_mode = 1'b0;
      load_random();
      model2d(1'b0);
      run(32'h1, 1'b1, 17);
      rd(8'd5, {16'd0, res[5]}, "smp5_after_meddle");
      check_all("mid");
      wr(ADDR_STATUS, 32'h2);
      rd(ADDR_STATUS, 32'd0, "done_clear");
      wr(ADDR_CTRL, 32'h2);
`ifdef DCT_IRQ_EN
      rd(ADDR_CTRL, 32'h2, "ctrl_irq_en");
`else
      rd(ADDR_CTRL, 32'h0, "ctrl_irq_en");
`endif
      wr(ADDR_CTRL, 32'h0);

      // Reset in ROW cycle i=6
      wr(8'd1, 32'h55);
      @(negedge clk);
      address = ADDR_CTRL; writedata = 32'h1; write = 1'b1;
      @(negedge clk);
      write = 1'b0; address = 8'd1; read = 1'b1;
      expect_push("pre_rst_smp1", 32'h55);
      @(negedge clk);
      read = 1'b0;
      expect_pop(rdm);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      #1;
      expect_push("midrst_rdata", 32'd0); expect_pop(rd0);
      expect_push("midrst_x0", 32'd0);    expect_pop(32'(|x0));
      @(negedge clk);
      rst = 1'b0;
      rd(ADDR_STATUS, 32'd0, "midrst_status");
      rd(ADDR_CTRL,   32'd0, "midrst_ctrl");
      run(32'h1, 1'b0, 17);

      // CORE_LAT=3 instance
      sel = 1'b1;
      load_random();
      model2d(1'b0);
      run(32'h1, 1'b0, 23);
      check_all("lat3");
      wr(ADDR_STATUS, 32'h2);
      rd(ADDR_STATUS, 32'd0, "lat3_done_clear");
      dc_mode = 1'b1;
      load_random();
      model2d(1'b1);
      run(32'h1, 1'b0, 23);
      check_all("lat3dc");
      dc_mode = 1'b0;
      sel = 1'b0;

`ifdef DCT_IRQ_EN
      run(32'h3, 1'b0, 17);
      expect_push("irq_rise", 32'h1); expect_pop({31'd0, irq0});
      wr(ADDR_STATUS, 32'h2);
      expect_push("irq_clear", 32'h0); expect_pop({31'd0, irq0});
      run(32'h1, 1'b0, 17);
      expect_push("irq_masked", 32'h0); expect_pop({31'd0, irq0});
`endif

      expect_push("scoreboard_drained", 32'd0);
      expect_pop(32'(exp_q.size() - 1));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   logic unused_irq1;
   assign unused_irq1 = irq1;

endmodule

`default_nettype wire

// File: doc/dct2d_seq_ctrl.md
Name: dct2d_seq_ctrl

Overview:
Sequences the combinational 8-point 1-D DCT core (16-bit, x0..x7 in, y0..y7 out) to compute a full 8x8 2-D DCT.
- Software loads 64 samples over an Avalon-MM slave and writes START.
- The block runs 8 row transforms, then 8 column transforms through a transpose buffer.
- Results are read back through the same sample window.
- Sits between the Avalon interconnect and one instance of the 1-D core.

Parameters:
- SAMPLE_W, 16: sample/coefficient width; must equal core width.
- CORE_LAT, 0: pipeline latency of the attached core in cycles (0 = combinational); legal range 0..4.

Ports:
- csi_clk  in  1  clock; all logic on rising edge.
- rsi_reset  in  1  asynchronous, active-high reset.
- avs_s0_address  in  8  word address.
- avs_s0_write  in  1  write strobe.
- avs_s0_writedata  in  32  write data.
- avs_s0_read  in  1  read strobe.
- avs_s0_readdata  out  32  registered read data.
- dct_x_o  out  8*SAMPLE_W  vector to core; x0 at [15:0], x7 at [127:112].
- dct_y_i  in  8*SAMPLE_W  core result; y0 at [15:0].

Behaviour:
- Register map:
  - 0x00-0x3F SAMPLE[a] at a = 8*row + col; R/W, low 16 bits used.
  - 0x40 CTRL: bit0 START (write-1 pulse), bit1 IRQ_EN.
  - 0x41 STATUS: bit0 BUSY (RO), bit1 DONE (sticky; write 1 clears).
  - Other addresses: writes ignored, reads return 0.
- Reads:
  - avs_s0_readdata updates on the clock edge where avs_s0_read=1 (1-cycle latency). Holds its value otherwise.
  - SAMPLE reads are zero-extended.
- Writes:
  - SAMPLE writes are ignored while BUSY.
  - START while BUSY is ignored.
  - START clears DONE.
- FSM states: IDLE, ROW, ROW_DRAIN, COL, COL_DRAIN, FIN.
  - IDLE: START -> ROW; BUSY=1 from the next cycle.
  - ROW: issue counter i=0..7, one per cycle; dct_x_o = buf row i. After i=7 -> ROW_DRAIN, or COL if CORE_LAT=0.
  - ROW_DRAIN: lasts CORE_LAT cycles, then -> COL.
  - Row capture: a delayed-valid shift register of depth CORE_LAT captures dct_y_i for row i into tr[i][0..7] CORE_LAT cycles after issue.
  - COL: issue c=0..7; dct_x_o = tr[0..7][c].
  - Column capture: result y_k is written to buf[8*k + c].
  - COL_DRAIN: lasts CORE_LAT cycles, then -> FIN.
  - FIN: one cycle; sets DONE, clears BUSY -> IDLE.
- Timing:
  - BUSY stays high exactly 16 + 2*CORE_LAT + 1 cycles.
  - DONE is visible on a STATUS read issued the cycle after FIN.
- Outside ROW/COL, dct_x_o = 0.
- Arithmetic: core outputs are stored unmodified (no scaling, no rounding). Overflow wraps at SAMPLE_W.
- Buffer reuse: the sample buffer holds the results after FIN. Column writes only happen after all row reads, so in-place reuse is safe.
- Simultaneous START and STATUS write-1-clear on separate cycles: each applies on its own cycle. On the same cycle a write targets a single address, so no conflict.
- Reset (async, any time, including mid-operation):
  - FSM -> IDLE; BUSY=0, DONE=0, IRQ_EN=0.
  - Counters and valid pipe cleared; avs_s0_readdata=0; dct_x_o=0.
  - Sample and transpose buffers are not reset; contents are undefined after reset.

Optional Feature:
- Macro DCT_IRQ_EN.
- Defined:
  - Adds output port ins_irq (1 bit) = DONE & IRQ_EN, registered.
  - Cleared when DONE is cleared or on reset.
- Undefined:
  - Port absent; CTRL bit1 reads 0 and writes are ignored.

Decomposition:
- Package dct_pkg:
  - SAMPLE_W, N=8.
  - Address constants ADDR_CTRL=8'h40, ADDR_STATUS=8'h41.
  - CTRL/STATUS bit indices.
  - State enum seq_state_t.
- Sub-module dct_buf_8x8:
  - 64 x SAMPLE_W storage.
  - Bus word read/write port.
  - Row-vector read, column-vector read, row-vector write and column-vector write ports.
  - Used twice: sample buffer and transpose buffer.

Test Plan:
- Passthrough core stub (y=x), CORE_LAT=0, SAMPLE[a]=a -> after DONE, every SAMPLE[a] reads a; BUSY high 17 cycles.
- DC stub (y0 = sum of x, others 0), all samples=1 -> SAMPLE[0]=64, all other 63 read 0.
- CORE_LAT=3 passthrough stub, random samples -> data unchanged; BUSY high 23 cycles; DONE=1; write STATUS=2 -> DONE=0.
- START while BUSY, plus SAMPLE[5]=0xBEEF write mid-run -> run length unchanged; SAMPLE[5] holds the computed result, not 0xBEEF.
- Assert rsi_reset at cycle 6 of ROW -> BUSY=0, DONE=0, readdata=0. A new START completes normally in 17 cycles.
- DCT_IRQ_EN defined, CTRL=3 -> ins_irq rises with DONE. STATUS write 2 drops it; with CTRL=1, ins_irq stays 0.
